// File: rtl/seg7_pkg.sv
// Segment codes (active-low {g,f,e,d,c,b,a}) and reader FSM states,
// shared between the countdown display driver and the loopback reader.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_LOCK
    } state_t;

    typedef struct packed {
        logic [6:0] seg2;
        logic [6:0] seg1;
    } seg_word_t;
endpackage

// File: rtl/seg7_reader_if.sv
// Two-digit segment bus into the reader plus the decoded result coming back out.
// master drives the segments and enable; slave is the reader.
interface seg7_reader_if;
    logic       en;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [5:0] value;
    logic       valid;
    logic       changed;
    logic       err;
    logic       stable;

    modport master (output en, seg1, seg2, input value, valid, changed, err, stable);
    modport slave  (input en, seg1, seg2, output value, valid, changed, err, stable);
endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-seg code to hex digit; legal=0 for any pattern outside the table.
// Zero latency; no flow control.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] code,
    output logic       legal,
    output logic [3:0] digit
);
    always_comb begin
        legal = 1'b1;
        digit = 4'h0;
        unique case (code)
            SEG_0:   digit = 4'h0;
            SEG_1:   digit = 4'h1;
            SEG_2:   digit = 4'h2;
            SEG_3:   digit = 4'h3;
            SEG_4:   digit = 4'h4;
            SEG_5:   digit = 4'h5;
            SEG_6:   digit = 4'h6;
            SEG_7:   digit = 4'h7;
            SEG_8:   digit = 4'h8;
            SEG_9:   digit = 4'h9;
            SEG_A:   digit = 4'hA;
            SEG_B:   digit = 4'hB;
            SEG_C:   digit = 4'hC;
            SEG_D:   digit = 4'hD;
            SEG_E:   digit = 4'hE;
            SEG_F:   digit = 4'hF;
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg7_reader.sv
// Synchronises, debounces and decodes the two-digit 7-seg bus back to a 6-bit value.
// Outputs follow a settled input change by SYNC_STAGES+STABLE_CYCLES+1 edges; no backpressure.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic         clk,
    input  logic         rst,
    seg7_reader_if.slave bus
);
    localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam seg_word_t        WORD_BLANK = '{seg2: SEG_BLANK, seg1: SEG_BLANK};

    seg_word_t        sync_q [SYNC_STAGES];
    seg_word_t        sync_w;
    seg_word_t        prev_q;
    logic [CNT_W-1:0] cnt_q;
    state_t           state_q;
    state_t           state_d;
    logic             moving;
    logic             accept;
    logic             stable_w;
    logic             lo_legal;
    logic             hi_legal;
    logic             word_legal;
    logic [3:0]       lo_digit;
    logic [3:0]       hi_digit;
    logic [5:0]       decoded;
    logic [5:0]       value_q;
    logic             valid_q;
    logic             changed_q;
    logic             err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= WORD_BLANK;
        end else begin
            sync_q[0] <= '{seg2: bus.seg2, seg1: bus.seg1};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];
    assign moving = (sync_w != prev_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= WORD_BLANK;
            cnt_q  <= '0;
        end else begin
            prev_q <= sync_w;
            if (!bus.en || moving) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // A word that changes in the very cycle it is accepted must be re-settled,
    // otherwise LOCK would never see the edge that already went past.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   state_d = S_SETTLE;
                S_SETTLE: if (accept) state_d = moving ? S_SETTLE : S_LOCK;
                S_LOCK:   if (moving) state_d = S_SETTLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        accept   = bus.en && (state_q == S_SETTLE) && (cnt_q == CNT_MAX);
        stable_w = (state_q == S_LOCK);
    end

    // prev_q holds the word that has just been stable for STABLE_CYCLES+1 samples.
    seg7_decode u_dec_lo (.code(prev_q.seg1), .legal(lo_legal), .digit(lo_digit));
    seg7_decode u_dec_hi (.code(prev_q.seg2), .legal(hi_legal), .digit(hi_digit));

    assign word_legal = lo_legal && hi_legal && (hi_digit < 4'd4);
    assign decoded    = {hi_digit[1:0], lo_digit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q   <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (accept) begin
                if (word_legal) begin
                    value_q   <= decoded;
                    valid_q   <= 1'b1;
                    err_q     <= 1'b0;
                    changed_q <= !valid_q || (decoded != value_q);
                end else begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.value   = value_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;
    assign bus.err     = err_q;
    assign bus.stable  = stable_w;
endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed vector table, hand sequences, and a
// randomized run checked against a run-length reference model.
module tb_seg7_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_reader_if bus ();
    seg7_reader dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [6:0] s1;
        logic [6:0] s2;
        int         hold;
        logic [5:0] value;
        logic       valid;
        logic       err;
        int         pulses;
        logic       stable;
    } vec_t;

    logic [6:0] seg_tab [16];
    vec_t       vecs [5];
    int n_checks = 0;
    int n_errors = 0;
    int pulses = 0;
    int back2back = 0;
    logic last_changed = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.changed === 1'b1) pulses++;
        if (bus.changed === 1'b1 && last_changed) back2back++;
        last_changed = bus.changed;
    endtask

    function automatic logic [13:0] enc(input logic [5:0] v);
        return {seg_tab[{2'b00, v[5:4]}], seg_tab[v[3:0]]};
    endfunction

    function automatic int code_idx(input logic [6:0] c);
        for (int d = 0; d < 16; d++) if (seg_tab[d] == c) return d;
        return -1;
    endfunction

    task automatic drive(input logic [13:0] w);
        bus.seg2 = w[13:7];
        bus.seg1 = w[6:0];
    endtask

    task automatic check_outputs(input string tag, input logic [5:0] v, input logic vl,
                                 input logic ch, input logic er, input logic st);
        check({tag, "_value"},   32'(bus.value),   32'(v));
        check({tag, "_valid"},   32'(bus.valid),   32'(vl));
        check({tag, "_changed"}, 32'(bus.changed), 32'(ch));
        check({tag, "_err"},     32'(bus.err),     32'(er));
        check({tag, "_stable"},  32'(bus.stable),  32'(st));
    endtask

    initial begin
        int first_pulse;
        logic [13:0] hist [$];
        logic [13:0] cur;
        int rem;
        logic [5:0] ref_value;
        logic ref_valid, ref_err, exp_changed;

        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0011000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        vecs[0] = '{seg_tab[3], seg_tab[1], 3,  6'h12, 1'b1, 1'b0, 0, 1'b0};
        vecs[1] = '{seg_tab[2], seg_tab[1], 10, 6'h12, 1'b1, 1'b0, 0, 1'b1};
        vecs[2] = '{7'h7F,      seg_tab[1], 10, 6'h12, 1'b0, 1'b1, 0, 1'b1};
        vecs[3] = '{seg_tab[5], seg_tab[8], 10, 6'h12, 1'b0, 1'b1, 0, 1'b1};
        vecs[4] = '{seg_tab[5], seg_tab[0], 10, 6'h05, 1'b1, 1'b0, 1, 1'b1};

        // Reset with random segments whose top bits keep them distinct from 0x12.
        rst = 1'b1;
        bus.en = 1'b0;
        bus.seg1 = {1'b1, 6'($urandom)};
        bus.seg2 = {1'b0, 6'($urandom)};
        #2 rst = 1'b0;
        repeat (3) step();
        check_outputs("reset", 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (10) step();
        check_outputs("idle_en0", 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Exact latency: input and enable applied before edge 0, update expected at edge 7.
        drive(enc(6'h12));
        bus.en = 1'b1;
        pulses = 0;
        first_pulse = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.changed === 1'b1 && first_pulse < 0) first_pulse = i;
        end
        check("first_latency", 32'(first_pulse), 32'd7);
        check("first_pulses", 32'(pulses), 32'd1);
        check_outputs("first", 6'h12, 1'b1, 1'b0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            bus.seg1 = vecs[i].s1;
            bus.seg2 = vecs[i].s2;
            pulses = 0;
            repeat (vecs[i].hold) step();
            check($sformatf("vec%0d_value", i),  32'(bus.value),  32'(vecs[i].value));
            check($sformatf("vec%0d_valid", i),  32'(bus.valid),  32'(vecs[i].valid));
            check($sformatf("vec%0d_err", i),    32'(bus.err),    32'(vecs[i].err));
            check($sformatf("vec%0d_pulses", i), 32'(pulses),     32'(vecs[i].pulses));
            check($sformatf("vec%0d_stable", i), 32'(bus.stable), 32'(vecs[i].stable));
        end

        // Countdown sweep 0x3F..0x00 then wrap to 0x3F, 8 cycles per value.
        for (int n = 0; n < 65; n++) begin
            logic [5:0] v;
            v = (n < 64) ? 6'(63 - n) : 6'h3F;
            drive(enc(v));
            pulses = 0;
            repeat (8) step();
            check($sformatf("sweep%0d_value", n),  32'(bus.value), 32'(v));
            check($sformatf("sweep%0d_pulses", n), 32'(pulses),    32'd1);
            check($sformatf("sweep%0d_err", n),    32'(bus.err),   32'd0);
        end

        // Asynchronous reset while settling on a new word.
        drive(enc(6'h12));
        repeat (3) step();
        rst = 1'b0;
        #1;
        check_outputs("midrst", 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        pulses = 0;
        repeat (12) step();
        check_outputs("after_rst", 6'h12, 1'b1, 1'b0, 1'b0, 1'b1);
        check("after_rst_pulses", 32'(pulses), 32'd1);

        // Enable dropped while settling: outputs held, nothing accepted.
        drive(enc(6'h05));
        repeat (3) step();
        bus.en = 1'b0;
        pulses = 0;
        repeat (10) step();
        check_outputs("en_drop", 6'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        check("en_drop_pulses", 32'(pulses), 32'd0);
        bus.en = 1'b1;
        pulses = 0;
        repeat (10) step();
        check_outputs("en_back", 6'h05, 1'b1, 1'b0, 1'b0, 1'b1);
        check("en_back_pulses", 32'(pulses), 32'd1);

        // Randomized run: a word is accepted iff it starts a run of >=5 identical
        // samples, with outputs moving exactly 7 edges after the run starts.
        ref_value = 6'h05;
        ref_valid = 1'b1;
        ref_err   = 1'b0;
        cur = enc(6'h05);
        for (int i = 0; i < 8; i++) hist.push_back(cur);
        rem = 0;
        for (int c = 0; c < 1500; c++) begin
            int e, k;
            if (rem == 0) begin
                if ($urandom_range(0, 7) == 0) cur = 14'($urandom);
                else cur = enc(6'($urandom));
                rem = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                  : int'($urandom_range(5, 10));
            end
            rem--;
            drive(cur);
            hist.push_back(cur);
            step();
            e = hist.size() - 1;
            k = e - 7;
            exp_changed = 1'b0;
            if (hist[k] != hist[k-1] && hist[k+1] == hist[k] && hist[k+2] == hist[k]
                && hist[k+3] == hist[k] && hist[k+4] == hist[k]) begin
                int lo, hi;
                lo = code_idx(hist[k][6:0]);
                hi = code_idx(hist[k][13:7]);
                if (lo >= 0 && hi >= 0 && hi < 4) begin
                    exp_changed = !ref_valid || (6'(hi * 16 + lo) != ref_value);
                    ref_value = 6'(hi * 16 + lo);
                    ref_valid = 1'b1;
                    ref_err   = 1'b0;
                end else begin
                    ref_valid = 1'b0;
                    ref_err   = 1'b1;
                end
            end
            check($sformatf("rand%0d", c),
                  32'({bus.value, bus.valid, bus.err, bus.changed}),
                  32'({ref_value, ref_valid, ref_err, exp_changed}));
        end

        check("no_consecutive_changed", 32'(back2back), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
